// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter and the memory unit.
//   - FSM state encoding (ST_IDLE, ST_WAIT)
//   - Owner encoding (OWN_A = instruction fetch, OWN_B = data access)
//   - Default bus widths shared with the memory unit
//   - Winner selection helper used by the arbiter
package bus_arbiter_pkg;

    localparam int unsigned BUS_ADDR_W = 27;
    localparam int unsigned BUS_DATA_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    typedef logic owner_t;
    localparam owner_t OWN_A = 1'b0;
    localparam owner_t OWN_B = 1'b1;

    // B wins unless only A is valid, or both are valid and A is preferred.
    function automatic owner_t select_owner(input logic a_valid, input logic b_valid,
                                            input logic prefer_a);
        if (a_valid && (!b_valid || prefer_a)) begin
            return OWN_A;
        end
        return OWN_B;
    endfunction

endpackage

// File: rtl/bus_req_slot.sv
// One pending-request slot in front of the shared memory bus.
// Captures {addr, data, we} on a start pulse when the slot is empty and the
// port has nothing in flight; cleared when the arbiter grants it.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle request pulse from the port
//   addr, data, we      request fields, sampled with start
//   busy                port currently owns the bus; new starts are ignored
//   grant               arbiter issued this slot onto the bus this cycle
//   valid               slot holds a request
//   slot_addr/data/we   captured request fields
module bus_req_slot
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = BUS_ADDR_W,
    parameter int unsigned DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              we,
    input  logic              busy,
    input  logic              grant,
    output logic              valid,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_data,
    output logic              slot_we
);

    logic load;

    // A start while full or in flight is a protocol violation: drop it.
    assign load = start && !valid && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= 1'b0;
            slot_addr <= '0;
            slot_data <= '0;
            slot_we   <= 1'b0;
        end else if (grant) begin
            valid <= 1'b0;
        end else if (load) begin
            valid     <= 1'b1;
            slot_addr <= addr;
            slot_data <= data;
            slot_we   <= we;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port arbiter for the single memory bus. Port A is instruction fetch,
// port B is data access. Requests are captured into per-port slots, issued
// one at a time onto the bus, and the done pulse / read data are routed back
// to the issuing port. All outputs are registered.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   a_addr/a_data/a_we/a_start        port A request
//   a_q/a_done                        port A completion
//   b_*                               same for port B
//   bus_addr/bus_data/bus_we/bus_start  request to the memory unit
//   bus_q/bus_done                    completion from the memory unit
// Build option:
//   BUS_ARBITER_ROUND_ROBIN_EN  when defined, contested grants alternate using
//                               a last-grant register; otherwise B beats A.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = BUS_ADDR_W,
    parameter int unsigned DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_we,
    input  logic              a_start,
    output logic [DATA_W-1:0] a_q,
    output logic              a_done,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_we,
    input  logic              b_start,
    output logic [DATA_W-1:0] b_q,
    output logic              b_done,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    output logic              bus_start,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     winner;
    logic       prefer_a;

    logic              a_valid, b_valid, a_slot_we, b_slot_we;
    logic [ADDR_W-1:0] a_slot_addr, b_slot_addr;
    logic [DATA_W-1:0] a_slot_data, b_slot_data;
    logic              a_busy, b_busy, a_grant, b_grant, issue;

    logic [ADDR_W-1:0] bus_addr_d;
    logic [DATA_W-1:0] bus_data_d, a_q_d, b_q_d;
    logic              bus_we_d, bus_start_d, a_done_d, b_done_d;

    // A port stays in flight until its bus_done is seen, so a re-request in
    // the bus_done cycle is already pending for the following IDLE cycle.
    assign a_busy = (state_q == ST_WAIT) && (owner_q == OWN_A) && !bus_done;
    assign b_busy = (state_q == ST_WAIT) && (owner_q == OWN_B) && !bus_done;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    owner_t last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWN_A;
        end else if (issue) begin
            last_grant_q <= winner;
        end
    end

    assign prefer_a = (last_grant_q == OWN_B);
`else
    assign prefer_a = 1'b0;
`endif

    assign winner  = select_owner(a_valid, b_valid, prefer_a);
    assign issue   = (state_q == ST_IDLE) && (a_valid || b_valid);
    assign a_grant = issue && (winner == OWN_A);
    assign b_grant = issue && (winner == OWN_B);

    bus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
        .clk       (clk),
        .reset     (reset),
        .start     (a_start),
        .addr      (a_addr),
        .data      (a_data),
        .we        (a_we),
        .busy      (a_busy),
        .grant     (a_grant),
        .valid     (a_valid),
        .slot_addr (a_slot_addr),
        .slot_data (a_slot_data),
        .slot_we   (a_slot_we)
    );

    bus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
        .clk       (clk),
        .reset     (reset),
        .start     (b_start),
        .addr      (b_addr),
        .data      (b_data),
        .we        (b_we),
        .busy      (b_busy),
        .grant     (b_grant),
        .valid     (b_valid),
        .slot_addr (b_slot_addr),
        .slot_data (b_slot_data),
        .slot_we   (b_slot_we)
    );

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_A;
            bus_addr  <= '0;
            bus_data  <= '0;
            bus_we    <= 1'b0;
            bus_start <= 1'b0;
            a_q       <= '0;
            a_done    <= 1'b0;
            b_q       <= '0;
            b_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            bus_addr  <= bus_addr_d;
            bus_data  <= bus_data_d;
            bus_we    <= bus_we_d;
            bus_start <= bus_start_d;
            a_q       <= a_q_d;
            a_done    <= a_done_d;
            b_q       <= b_q_d;
            b_done    <= b_done_d;
        end
    end

    // Next-state logic; bus_done in IDLE is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue)    state_d = ST_WAIT;
            ST_WAIT: if (bus_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Output logic: bus fields hold during WAIT, pulses default low.
    always_comb begin
        owner_d     = owner_q;
        bus_addr_d  = bus_addr;
        bus_data_d  = bus_data;
        bus_we_d    = bus_we;
        bus_start_d = 1'b0;
        a_q_d       = a_q;
        a_done_d    = 1'b0;
        b_q_d       = b_q;
        b_done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    bus_start_d = 1'b1;
                    owner_d     = winner;
                    if (winner == OWN_B) begin
                        bus_addr_d = b_slot_addr;
                        bus_data_d = b_slot_data;
                        bus_we_d   = b_slot_we;
                    end else begin
                        bus_addr_d = a_slot_addr;
                        bus_data_d = a_slot_data;
                        bus_we_d   = a_slot_we;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_done) begin
                    if (owner_q == OWN_B) begin
                        b_q_d    = bus_q;
                        b_done_d = 1'b1;
                    end else begin
                        a_q_d    = bus_q;
                        a_done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
